// File: rtl/amstrad_asic_pkg.sv
// Shared constants and types for the Plus/GX4000 ASIC register responder:
// the unlock byte sequence, register page addresses and unlock FSM states.
package amstrad_asic_pkg;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_SEQ      = 2'd1,
      ST_UNLOCKED = 2'd2
   } unlock_state_e;

   localparam logic [7:0] UNLOCK_SEQ [16] = '{
      8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
      8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD
   };
   localparam logic [7:0] UNLOCK_KEY = 8'hEE;

   localparam logic [15:0] PAL_BASE      = 16'h6400;
   localparam logic [15:0] RASTER_IRQ    = 16'h6800;
   localparam logic [15:0] SPLIT_LINE    = 16'h6801;
   localparam logic [15:0] SPLIT_ADDR_HI = 16'h6802;
   localparam logic [15:0] SPLIT_ADDR_LO = 16'h6803;
   localparam logic [15:0] SOFT_SCROLL   = 16'h6804;

endpackage

// File: rtl/asic_unlock_fsm.sv
// ASIC unlock sequence tracker: counts matching bytes written to the CRTC
// select port and unlocks on the final 8'hEE key byte.
module asic_unlock_fsm
   import amstrad_asic_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       strobe_i,
   input  logic [7:0] data_i,
   input  logic       plus_mode_i,
   output logic       unlocked_o,
   output logic [4:0] idx_o
);

   unlock_state_e state_q, state_d;
   logic [4:0]    idx_q, idx_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_LOCKED;
         idx_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (!plus_mode_i) begin
         state_d = ST_LOCKED;
         idx_d   = 5'd0;
      end else if (strobe_i) begin
         if (idx_q == 5'd16) begin
            idx_d   = 5'd0;
            state_d = (data_i == UNLOCK_KEY) ? ST_UNLOCKED : ST_LOCKED;
         end else begin
            if (data_i == UNLOCK_SEQ[idx_q[3:0]])
               idx_d = idx_q + 5'd1;
            else
               idx_d = (data_i == 8'hFF) ? 5'd1 : 5'd0;
            // An unlocked ASIC stays unlocked while a re-run is in progress.
            if (state_q != ST_UNLOCKED)
               state_d = (idx_d != 5'd0) ? ST_SEQ : ST_LOCKED;
         end
      end
   end

   assign unlocked_o = (state_q == ST_UNLOCKED);
   assign idx_o      = idx_q;

endmodule

// File: rtl/amstrad_asic_regs.sv
// Plus/GX4000 ASIC register responder: unlock FSM, RMR2 and the 0x4000-0x7FFF
// register page. Define ASIC_REG_READBACK_EN to make register reads return stored values.
module amstrad_asic_regs
   import amstrad_asic_pkg::*;
#(
   parameter int unsigned PAL_ENTRIES = 32,
   parameter logic [7:0]  RMR2_RESET  = 8'h00
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        plus_mode,
   input  logic        io_WR,
   input  logic        mem_WR,
   input  logic        mem_RD,
   input  logic [15:0] A,
   input  logic [7:0]  D,
   input  logic        asic_reg_sel,
   output logic [7:0]  asic_dout,
   output logic        asic_enabled,
   output logic [7:0]  rmr2,
   output logic [7:0]  raster_irq,
   output logic [7:0]  split_line,
   output logic [15:0] split_addr,
   output logic [7:0]  soft_scroll,
   input  logic [4:0]  pal_idx,
   output logic [11:0] pal_rgb
);

   logic        old_wr_q, old_mwr_q;
   logic        io_edge, mwr_edge, reg_we;
   logic        unlocked;
   logic [4:0]  unused_idx;
   logic        pal_hit;
   logic [4:0]  pal_n;
   logic [7:0]  rd_data, dout_d;
   logic [7:0]  dout_q, rmr2_q, raster_q, split_line_q, soft_q;
   logic [15:0] split_addr_q;
   logic [11:0] pal_rgb_q;
   logic [11:0] pal_q [PAL_ENTRIES];

   assign io_edge  = io_WR & ~old_wr_q;
   assign mwr_edge = mem_WR & ~old_mwr_q;
   assign reg_we   = mwr_edge & asic_reg_sel & unlocked;

   asic_unlock_fsm u_unlock (
      .clk_i       (CLK),
      .rst_ni      (reset_n),
      .strobe_i    (io_edge & ~A[14] & (A[9:8] == 2'b00)),
      .data_i      (D),
      .plus_mode_i (plus_mode),
      .unlocked_o  (unlocked),
      .idx_o       (unused_idx)
   );

   // Palette sits on a 64-byte boundary, so the entry index is A[5:1].
   assign pal_hit = (A[15:6] == PAL_BASE[15:6]) && ({1'b0, A[5:1]} < 6'(PAL_ENTRIES));
   assign pal_n   = A[5:1];

   always_ff @(posedge CLK) begin
      if (reg_we && pal_hit && !A[0]) pal_q[pal_n][7:0]  <= D;
      if (reg_we && pal_hit &&  A[0]) pal_q[pal_n][11:8] <= D[3:0];
   end

   always_comb begin
      rd_data = 8'hFF;
`ifdef ASIC_REG_READBACK_EN
      if (pal_hit) begin
         rd_data = A[0] ? {4'h0, pal_q[pal_n][11:8]} : pal_q[pal_n][7:0];
      end else begin
         case (A)
            RASTER_IRQ:    rd_data = raster_q;
            SPLIT_LINE:    rd_data = split_line_q;
            SPLIT_ADDR_HI: rd_data = split_addr_q[15:8];
            SPLIT_ADDR_LO: rd_data = split_addr_q[7:0];
            SOFT_SCROLL:   rd_data = soft_q;
            default:       rd_data = 8'hFF;
         endcase
      end
`endif
      dout_d = (mem_RD && asic_reg_sel) ? rd_data : 8'hFF;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         old_wr_q     <= 1'b0;
         old_mwr_q    <= 1'b0;
         dout_q       <= 8'h00;
         rmr2_q       <= RMR2_RESET;
         raster_q     <= 8'h00;
         split_line_q <= 8'h00;
         split_addr_q <= 16'h0000;
         soft_q       <= 8'h00;
         pal_rgb_q    <= 12'h000;
      end else begin
         old_wr_q  <= io_WR;
         old_mwr_q <= mem_WR;
         dout_q    <= dout_d;
         pal_rgb_q <= pal_q[pal_idx];
         if (io_edge && !A[15] && (D[7:5] == 3'b101) && unlocked)
            rmr2_q <= {3'b000, D[4:0]};
         if (reg_we) begin
            case (A)
               RASTER_IRQ:    raster_q           <= D;
               SPLIT_LINE:    split_line_q       <= D;
               SPLIT_ADDR_HI: split_addr_q[15:8] <= D;
               SPLIT_ADDR_LO: split_addr_q[7:0]  <= D;
               SOFT_SCROLL:   soft_q             <= D;
               default:       ;
            endcase
         end
      end
   end

   assign asic_dout    = dout_q;
   assign asic_enabled = unlocked;
   assign rmr2         = rmr2_q;
   assign raster_irq   = raster_q;
   assign split_line   = split_line_q;
   assign split_addr   = split_addr_q;
   assign soft_scroll  = soft_q;
   assign pal_rgb      = pal_rgb_q;

endmodule
